logic_unit_arbiter: RTL and testbench
=====================================

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: width of the per-requester grant counters (used only when LU_ARB_CNT_EN is defined).
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have ports req0_valid and req1_valid, input, 1: requester N presents an operation.
REQ-005 The block SHALL have ports req0_ready and req1_ready, output, 1: requester N's operation is accepted this cycle.
REQ-006 The block SHALL have ports req0_op and req1_op, input, 3: operation select for requester N.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a and req1_b, input, 32: operands for requester N.
REQ-008 The block SHALL have port rsp_valid, output, 1: a result is held.
REQ-009 The block SHALL have port rsp_ready, input, 1: the consumer accepts the result.
REQ-010 The block SHALL have port rsp_data, output, 32: the registered result.
REQ-011 The block SHALL have port rsp_id, output, 1: the index of the requester that produced rsp_data.
REQ-012 The block SHALL have ports grant_cnt0 and grant_cnt1, output, CNT_W, present only when LU_ARB_CNT_EN is defined: the grant count for requester N.

Function
REQ-013 The block SHALL contain exactly one instance of the combinational logic_unit, shared between both requesters.
REQ-014 The op encoding SHALL be: 000 AND, 001 XOR, 010 NAND, 011 OR, 100 NOT a, 101 NOR, 110 two's complement of a, 111 XNOR.
REQ-015 The FSM SHALL have two states: IDLE (no result held) and HOLD (result held, rsp_valid=1).
REQ-016 A grant SHALL be possible when the state is IDLE, or when the state is HOLD and rsp_ready=1 (drain-and-refill in the same cycle).
REQ-017 When a grant is possible and at least one reqN_valid=1, exactly one reqN_ready SHALL be driven to 1, combinationally in the same cycle; both SHALL be 0 otherwise.
REQ-018 Arbitration SHALL be round-robin: a lone valid requester wins; if both are valid, the requester that is not rr_last wins.
REQ-019 On a grant, the winner's logic_unit result SHALL be registered into rsp_data and the winner's index into rsp_id, rr_last SHALL be set to the winner, and the state SHALL become HOLD (latency of 1 cycle from acceptance to rsp_valid).
REQ-020 In HOLD with rsp_ready=0, rsp_data and rsp_id SHALL remain stable and both reqN_ready SHALL be 0.
REQ-021 In HOLD with rsp_ready=1 and no valid request, the state SHALL become IDLE and rsp_valid SHALL deassert on the next cycle.
REQ-022 Sustained throughput SHALL be one operation per cycle while rsp_ready=1.
REQ-023 Operands SHALL be sampled only in the grant cycle; changes to a requester's inputs while its reqN_ready=0 SHALL have no effect.

Reset
REQ-024 While rst=1, the block SHALL asynchronously force: state IDLE, rsp_valid 0, rsp_data 0x00000000, rsp_id 0, rr_last 1 (so requester 0 wins the first tie), grant counters 0.
REQ-025 While rst=1, req0_ready and req1_ready SHALL be 0.
REQ-026 A reset asserted in HOLD SHALL discard the held result without it being delivered.

Configuration
REQ-027 With macro LU_ARB_CNT_EN defined, grant_cntN SHALL increment by 1 on each grant to requester N and SHALL saturate at all-ones (no wrap).
REQ-028 Without LU_ARB_CNT_EN, the counters and the grant_cnt ports SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Directed: req0 only, op=000, a=0xF0F0F0F0, b=0x0FF00FF0 -> next cycle rsp_valid=1, rsp_data=0x00F000F0, rsp_id=0.
REQ-030 Directed: req1 only, op=110, a=0x00000001 -> rsp_data=0xFFFFFFFF, rsp_id=1; op=100, a=0x0000FFFF -> rsp_data=0xFFFF0000.
REQ-031 Directed: both valid continuously after reset, rsp_ready=1 -> rsp_id sequence 0,1,0,1 on consecutive cycles, with one result per cycle.
REQ-032 Directed: rsp_ready=0 for 5 cycles while in HOLD, with both requesters valid -> rsp_data and rsp_id stable, reqN_ready=0 throughout.
REQ-033 Directed: rst pulsed while in HOLD -> rsp_valid=0 immediately; after release, the next tie is won by requester 0.
REQ-034 Directed (LU_ARB_CNT_EN defined, CNT_W=2): 5 grants to requester 0 -> grant_cnt0=3 (saturated), grant_cnt1=0.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// logic_unit_arbiter
//
// Two requesters share a single combinational logic unit. A round-robin
// arbiter picks one operation per cycle, the result is registered and held
// behind a valid/ready response port until the consumer takes it. A new
// operation may be accepted in the same cycle the held result drains.
//
// Optional feature (macro LU_ARB_CNT_EN): per-requester saturating grant
// counters exported on grant_cnt0 / grant_cnt1.
//
// Ports
//   clk                    : clock, rising edge
//   rst                    : asynchronous active-high reset
//   reqN_valid             : requester N presents an operation
//   reqN_ready             : requester N's operation is accepted this cycle
//   reqN_op[2:0]           : operation select
//   reqN_a/b[31:0]         : operands
//   rsp_valid              : a result is held
//   rsp_ready              : consumer accepts the result
//   rsp_data[31:0]         : registered result
//   rsp_id                 : requester that produced rsp_data
//   grant_cntN[CNT_W-1:0]  : grant count for requester N (LU_ARB_CNT_EN only)
// ---------------------------------------------------------------------------

// Combinational bitwise logic unit.
//   000 AND   001 XOR   010 NAND  011 OR
//   100 NOT a 101 NOR   110 -a    111 XNOR
module logic_unit (
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  always_comb begin
    y = '0;
    case (op)
      3'b000: y = a & b;
      3'b001: y = a ^ b;
      3'b010: y = ~(a & b);
      3'b011: y = a | b;
      3'b100: y = ~a;
      3'b101: y = ~(a | b);
      3'b110: y = (~a) + 32'd1;
      3'b111: y = ~(a ^ b);
      default: y = '0;
    endcase
  end
endmodule

module logic_unit_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [31:0]       req0_a,
  input  logic [31:0]       req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [31:0]       req1_a,
  input  logic [31:0]       req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_id
`ifdef LU_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
`endif
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_id_q, rsp_id_d;
  logic        rr_last_q, rr_last_d;

  logic        grant_possible;
  logic        grant;
  logic        win_id;
  logic [2:0]  lu_op;
  logic [31:0] lu_a, lu_b, lu_y;

  // Arbitration: a lone requester wins; on a tie the one that did not win
  // last time goes. Ready is also masked by rst so nothing is accepted
  // while the block is being reset.
  always_comb begin
    grant_possible = (state_q == IDLE) || rsp_ready;
    win_id         = (req0_valid && req1_valid) ? ~rr_last_q : req1_valid;
    grant          = ~rst && grant_possible && (req0_valid || req1_valid);
    req0_ready     = grant && !win_id;
    req1_ready     = grant && win_id;
  end

  // Operand mux in front of the single shared logic unit.
  always_comb begin
    lu_op = win_id ? req1_op : req0_op;
    lu_a  = win_id ? req1_a  : req0_a;
    lu_b  = win_id ? req1_b  : req0_b;
  end

  logic_unit u_lu (
    .op (lu_op),
    .a  (lu_a),
    .b  (lu_b),
    .y  (lu_y)
  );

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rr_last_d  = rr_last_q;
    if (grant) begin
      // Covers both the IDLE fill and the HOLD drain-and-refill case.
      state_d    = HOLD;
      rsp_data_d = lu_y;
      rsp_id_d   = win_id;
      rr_last_d  = win_id;
    end else if ((state_q == HOLD) && rsp_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      rr_last_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rr_last_q  <= rr_last_d;
    end
  end

  assign rsp_valid = (state_q == HOLD);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

`ifdef LU_ARB_CNT_EN
  logic [CNT_W-1:0] grant_cnt0_q, grant_cnt0_d;
  logic [CNT_W-1:0] grant_cnt1_q, grant_cnt1_d;

  // Saturating counters: stick at all-ones instead of wrapping.
  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (req0_ready && (grant_cnt0_q != '1)) grant_cnt0_d = grant_cnt0_q + 1'b1;
    if (req1_ready && (grant_cnt1_q != '1)) grant_cnt1_d = grant_cnt1_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_arbiter
//
// Self-checking bench for logic_unit_arbiter. A reference model tracks the
// arbiter at transaction level (holding / not holding, who won last) and
// pushes the expected response into a queue on every accepted operation;
// an independent monitor checks readies and pops/compares responses.
// With LU_ARB_CNT_EN defined the bench uses CNT_W=2 and checks counters.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_logic_unit_arbiter;
`ifdef LU_ARB_CNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;
`ifdef LU_ARB_CNT_EN
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

  logic_unit_arbiter #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id)
`ifdef LU_ARB_CNT_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of the logic unit straight from the op table.
  function automatic logic [31:0] lu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a ^ b;
      3'd2: return ~(a & b);
      3'd3: return a | b;
      3'd4: return ~a;
      3'd5: return ~(a | b);
      3'd6: return 32'd0 - a;
      default: return ~(a ^ b);
    endcase
  endfunction

  typedef struct { logic id; logic [31:0] data; } rsp_t;
  rsp_t exp_q[$];

  // Transaction-level model state.
  bit m_hold;
  bit m_last;
  int m_cnt0, m_cnt1;

  function automatic bit model_grant();
    return (!m_hold || rsp_ready) && (req0_valid || req1_valid);
  endfunction

  function automatic bit model_winner();
    if (req0_valid && req1_valid) return !m_last;
    return req1_valid;
  endfunction

  // Model: advance on each rising edge using the inputs applied this cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_hold = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
      exp_q.delete();
    end else if (model_grant()) begin
      rsp_t r;
      bit   w;
      w      = model_winner();
      r.id   = w;
      r.data = w ? lu_ref(req1_op, req1_a, req1_b) : lu_ref(req0_op, req0_a, req0_b);
      exp_q.push_back(r);
      m_hold = 1; m_last = w;
      if (w) m_cnt1 = (m_cnt1 == (1 << CNT_W) - 1) ? m_cnt1 : m_cnt1 + 1;
      else   m_cnt0 = (m_cnt0 == (1 << CNT_W) - 1) ? m_cnt0 : m_cnt0 + 1;
    end else if (m_hold && rsp_ready) begin
      m_hold = 0;
    end
  end

  // Monitor: check readies and the presented response at mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      bit g, w;
      g = model_grant();
      w = model_winner();
      check("req0_ready", {31'd0, req0_ready}, {31'd0, g && !w});
      check("req1_ready", {31'd0, req1_ready}, {31'd0, g && w});
      check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_q.size() != 0});
      if (rsp_valid && exp_q.size() != 0) begin
        check("rsp_data", rsp_data, exp_q[0].data);
        check("rsp_id", {31'd0, rsp_id}, {31'd0, exp_q[0].id});
        if (rsp_ready) void'(exp_q.pop_front());
      end
`ifdef LU_ARB_CNT_EN
      check("grant_cnt0", 32'(grant_cnt0), 32'(m_cnt0));
      check("grant_cnt1", 32'(grant_cnt1), 32'(m_cnt1));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v0, input logic [2:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [2:0] o1, input logic [31:0] a1, input logic [31:0] b1);
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
  endtask

  logic [31:0] held_data;
  logic        held_id;

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    set_req(1, 3'd0, 32'h1, 32'h1, 1, 3'd0, 32'h2, 32'h2);
    #3;
    // Reset values, with both requesters asserting valid.
    check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst rsp_data", rsp_data, 32'd0);
    check("rst rsp_id", {31'd0, rsp_id}, 32'd0);
    check("rst req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst req1_ready", {31'd0, req1_ready}, 32'd0);
    step();
    set_req(0, 3'd0, 32'h0, 32'h0, 0, 3'd0, 32'h0, 32'h0);
    rst = 1'b0;
    step();

    // Requester 0 alone, AND.
    set_req(1, 3'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 3'd0, 32'h0, 32'h0);
    step();
    set_req(0, 3'd0, 32'h0, 32'h0, 0, 3'd0, 32'h0, 32'h0);
    check("and rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("and rsp_data", rsp_data, 32'h00F000F0);
    check("and rsp_id", {31'd0, rsp_id}, 32'd0);
    step();

    // Requester 1 alone, negate then NOT a.
    set_req(0, 3'd0, 32'h0, 32'h0, 1, 3'd6, 32'h00000001, 32'h12345678);
    step();
    check("neg rsp_data", rsp_data, 32'hFFFFFFFF);
    check("neg rsp_id", {31'd0, rsp_id}, 32'd1);
    set_req(0, 3'd0, 32'h0, 32'h0, 1, 3'd4, 32'h0000FFFF, 32'h0);
    step();
    set_req(0, 3'd0, 32'h0, 32'h0, 0, 3'd0, 32'h0, 32'h0);
    check("not rsp_data", rsp_data, 32'hFFFF0000);
    step();

    // Both valid continuously: alternate 0,1,0,1 one per cycle.
    set_req(1, 3'd3, 32'hA5A50000, 32'h00005A5A, 1, 3'd1, 32'hFFFF0000, 32'h0F0F0F0F);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("rr rsp_id", {31'd0, rsp_id}, 32'(i % 2));
    end

    // Back-pressure: held result stays put, nobody is accepted.
    rsp_ready = 1'b0;
    step();
    held_data = rsp_data;
    held_id   = rsp_id;
    for (int i = 0; i < 5; i++) begin
      req0_a = $urandom; req1_a = $urandom;
      check("hold data", rsp_data, held_data);
      check("hold id", {31'd0, rsp_id}, {31'd0, held_id});
      check("hold readies", {30'd0, req1_ready, req0_ready}, 32'd0);
      step();
    end

    // Reset in HOLD drops the result at once; first tie then goes to 0.
    #2;
    rst = 1'b1;
    #1;
    check("rst-hold rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst-hold readies", {30'd0, req1_ready, req0_ready}, 32'd0);
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    step();
    check("post-rst tie id", {31'd0, rsp_id}, 32'd0);
    check("post-rst rsp_valid", {31'd0, rsp_valid}, 32'd1);

    // Randomized traffic, operands changing every cycle.
    for (int i = 0; i < 400; i++) begin
      set_req($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom, $urandom,
              $urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom, $urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Drain.
    set_req(0, 3'd0, 32'h0, 32'h0, 0, 3'd0, 32'h0, 32'h0);
    rsp_ready = 1'b1;
    step();
    step();
    check("drained rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("drained queue", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
